// File: rtl/rv32i_pkg.sv
// Shared fetch-unit definitions: state encoding and instruction constants.
package rv32i_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2,
        FS_HALT = 2'd3
    } fetch_state_e;

    localparam int              ILEN     = 32;
    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;
    localparam int              PC_STEP  = 4;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit signal bundle: memory read port, execute redirect and decode handoff.
interface inst_fetch_if #(
    parameter int XLEN = 32
) ();
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic            misalign;

    modport master (
        output mem_req, mem_addr, id_valid, id_inst, id_pc, misalign,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  mem_req, mem_addr, id_valid, id_inst, id_pc, misalign,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous fetch queue with flush; head is read straight from storage so it is registered.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A full queue still accepts a push when the head leaves on the same edge
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, keeps one memory read in flight, queues words for decode.
// Define IFETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
//
//  state   | meaning
//  FS_REQ  | request pc when queue space allows
//  FS_WAIT | read granted, waiting for rvalid
//  FS_DROP | a redirect orphaned the in-flight read; swallow its rvalid
//  FS_HALT | misaligned redirect seen; idle until aligned redirect or reset
module inst_fetch
    import rv32i_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    inst_fetch_if.master fif
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic              outst_q, outst_d;
    logic              misalign_q, misalign_d;
    logic              issue, accept, push, pop, redir_bad;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;

    assign redir_bad = fif.redirect && (fif.redirect_pc[1:0] != 2'b00);
    assign accept    = issue && fif.mem_gnt;
    assign pop       = fif.id_valid && fif.id_ready;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= FS_REQ;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fif.redirect) begin
            // Any read still in flight after this edge must be discarded
            if (redir_bad)    state_d = FS_HALT;
            else if (outst_d) state_d = FS_DROP;
            else              state_d = FS_REQ;
        end else begin
            case (state_q)
                FS_REQ:  if (accept)         state_d = FS_WAIT;
                FS_WAIT: if (fif.mem_rvalid) state_d = FS_REQ;
                FS_DROP: if (fif.mem_rvalid) state_d = FS_REQ;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        if (rst && (state_q == FS_REQ) && ((count + CW'(outst_q)) < DEPTH_C)) issue = 1'b1;
        if ((state_q == FS_WAIT) && fif.mem_rvalid && !fif.redirect)           push  = 1'b1;
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        outst_d    = outst_q;
        misalign_d = misalign_q;
        if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(PC_STEP);
            outst_d  = 1'b1;
        end else if (fif.mem_rvalid) begin
            outst_d  = 1'b0;
        end
        if (fif.redirect) begin
            pc_d = fif.redirect_pc;
            if (redir_bad) misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            outst_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            outst_q    <= outst_d;
            misalign_q <= misalign_d;
        end
    end

    ifetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fif.redirect),
        .push_i  (push),
        .wdata_i ({req_pc_q, fif.mem_rdata}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    assign fif.mem_req  = issue;
    assign fif.mem_addr = pc_q;
    assign fif.id_valid = (count != '0);
    assign fif.id_pc    = head[2*XLEN-1:XLEN];
    assign fif.id_inst  = fif.id_valid ? head[XLEN-1:0] : XLEN'(INST_NOP);
    assign fif.misalign = misalign_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop)                            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (fif.id_valid && !fif.id_ready)  stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-outstanding, 1-cycle-latency memory model.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if #(.XLEN(32)) fif ();

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    inst_fetch #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    bit          rv_hold = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    // memory: grants when idle, answers one cycle later unless held; forgets on reset
    always @(posedge clk) begin
        if (!rst) pend = 1'b0;
        else begin
            if (fif.mem_rvalid) pend = 1'b0;
            if (fif.mem_req && fif.mem_gnt) begin
                pend      = 1'b1;
                pend_addr = fif.mem_addr;
            end
        end
    end

    always @(negedge clk) begin
        fif.mem_gnt    = fif.mem_req && !pend;
        fif.mem_rvalid = pend && !rv_hold;
        fif.mem_rdata  = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!fif.id_valid && n < 30) begin
            step();
            n++;
        end
        if (!fif.id_valid) begin
            checks++; errors++;
            $display("FAIL %s: id_valid not seen within 30 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (fif.mem_req !== 1'b0)      begin errors++; $display("FAIL rst_mem_req: got %b want 0", fif.mem_req); end
        checks++; if (fif.id_valid !== 1'b0)     begin errors++; $display("FAIL rst_id_valid: got %b want 0", fif.id_valid); end
        checks++; if (fif.misalign !== 1'b0)     begin errors++; $display("FAIL rst_misalign: got %b want 0", fif.misalign); end
        checks++; if (fif.mem_addr !== 32'h0)    begin errors++; $display("FAIL rst_mem_addr: got %h want 0", fif.mem_addr); end
`ifdef IFETCH_PERF_EN
        checks++; if (perf_fetch_cnt !== 32'h0)  begin errors++; $display("FAIL rst_perf_fetch: got %0d want 0", perf_fetch_cnt); end
        checks++; if (perf_stall_cnt !== 32'h0)  begin errors++; $display("FAIL rst_perf_stall: got %0d want 0", perf_stall_cnt); end
`endif
        rst = 1'b1;
        #1;
        checks++; if (fif.mem_req !== 1'b1)      begin errors++; $display("FAIL first_mem_req: got %b want 1", fif.mem_req); end
        checks++; if (fif.mem_addr !== 32'h0)    begin errors++; $display("FAIL first_mem_addr: got %h want 0", fif.mem_addr); end
    endtask

    task automatic test_fetch_seq();
        fif.id_ready = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            wait_valid("seq_valid");
            checks++; if (fif.id_pc !== exp_pc)             begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, fif.id_pc, exp_pc); end
            checks++; if (fif.id_inst !== mem_word(exp_pc)) begin errors++; $display("FAIL seq_inst[%0d]: got %h want %h", i, fif.id_inst, mem_word(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
`ifdef IFETCH_PERF_EN
        checks++; if (perf_fetch_cnt !== 32'd5) begin errors++; $display("FAIL perf_fetch: got %0d want 5", perf_fetch_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        fif.id_ready = 1'b0;
        repeat (10) step();
        checks++; if (fif.id_valid !== 1'b1)          begin errors++; $display("FAIL bp_valid: got %b want 1", fif.id_valid); end
        checks++; if (fif.mem_req !== 1'b0)           begin errors++; $display("FAIL bp_mem_req: got %b want 0", fif.mem_req); end
        checks++; if (fif.mem_addr !== exp_pc + 32'd8) begin errors++; $display("FAIL bp_mem_addr: got %h want %h", fif.mem_addr, exp_pc + 32'd8); end
        checks++; if (fif.id_pc !== exp_pc)           begin errors++; $display("FAIL bp_head_pc: got %h want %h", fif.id_pc, exp_pc); end
        step();
        checks++; if (fif.id_pc !== exp_pc)             begin errors++; $display("FAIL bp_stable_pc: got %h want %h", fif.id_pc, exp_pc); end
        checks++; if (fif.id_inst !== mem_word(exp_pc)) begin errors++; $display("FAIL bp_stable_inst: got %h want %h", fif.id_inst, mem_word(exp_pc)); end
        fif.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid("bp_valid_rel");
            checks++; if (fif.id_pc !== exp_pc)             begin errors++; $display("FAIL bp_pc[%0d]: got %h want %h", i, fif.id_pc, exp_pc); end
            checks++; if (fif.id_inst !== mem_word(exp_pc)) begin errors++; $display("FAIL bp_inst[%0d]: got %h want %h", i, fif.id_inst, mem_word(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_redirect_wait();
        fif.id_ready = 1'b1;
        rv_hold = 1'b1;
        repeat (6) step();
        checks++; if (fif.mem_req !== 1'b0) begin errors++; $display("FAIL rw_wait_req: got %b want 0", fif.mem_req); end
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h100;
        step();
        fif.redirect = 1'b0;
        checks++; if (fif.id_valid !== 1'b0)    begin errors++; $display("FAIL rw_flush: got %b want 0", fif.id_valid); end
        checks++; if (fif.mem_req !== 1'b0)     begin errors++; $display("FAIL rw_drop_req: got %b want 0", fif.mem_req); end
        checks++; if (fif.mem_addr !== 32'h100) begin errors++; $display("FAIL rw_addr: got %h want 100", fif.mem_addr); end
        rv_hold = 1'b0;
        exp_pc = 32'h100;
        for (int i = 0; i < 2; i++) begin
            wait_valid("rw_valid");
            checks++; if (fif.id_pc !== exp_pc)             begin errors++; $display("FAIL rw_pc[%0d]: got %h want %h", i, fif.id_pc, exp_pc); end
            checks++; if (fif.id_inst !== mem_word(exp_pc)) begin errors++; $display("FAIL rw_inst[%0d]: got %h want %h", i, fif.id_inst, mem_word(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_misalign();
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h102;
        step();
        fif.redirect = 1'b0;
        checks++; if (fif.misalign !== 1'b1) begin errors++; $display("FAIL ma_flag: got %b want 1", fif.misalign); end
        checks++; if (fif.mem_req !== 1'b0)  begin errors++; $display("FAIL ma_req: got %b want 0", fif.mem_req); end
        checks++; if (fif.id_valid !== 1'b0) begin errors++; $display("FAIL ma_valid: got %b want 0", fif.id_valid); end
        repeat (4) step();
        checks++; if (fif.mem_req !== 1'b0)  begin errors++; $display("FAIL ma_halt_req: got %b want 0", fif.mem_req); end
        checks++; if (fif.id_valid !== 1'b0) begin errors++; $display("FAIL ma_halt_valid: got %b want 0", fif.id_valid); end
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h200;
        step();
        fif.redirect = 1'b0;
        exp_pc = 32'h200;
        for (int i = 0; i < 2; i++) begin
            wait_valid("ma_valid_resume");
            checks++; if (fif.id_pc !== exp_pc)             begin errors++; $display("FAIL ma_pc[%0d]: got %h want %h", i, fif.id_pc, exp_pc); end
            checks++; if (fif.id_inst !== mem_word(exp_pc)) begin errors++; $display("FAIL ma_inst[%0d]: got %h want %h", i, fif.id_inst, mem_word(exp_pc)); end
            checks++; if (fif.misalign !== 1'b1)            begin errors++; $display("FAIL ma_sticky[%0d]: got %b want 1", i, fif.misalign); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_wrap();
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'hFFFF_FFFC;
        step();
        fif.redirect = 1'b0;
        wait_valid("wrap_valid_top");
        checks++; if (fif.id_pc !== 32'hFFFF_FFFC)             begin errors++; $display("FAIL wrap_pc_top: got %h want fffffffc", fif.id_pc); end
        checks++; if (fif.id_inst !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_inst_top: got %h want %h", fif.id_inst, mem_word(32'hFFFF_FFFC)); end
        checks++; if (fif.mem_addr !== 32'h0)                  begin errors++; $display("FAIL wrap_addr: got %h want 0", fif.mem_addr); end
        step();
        wait_valid("wrap_valid_zero");
        checks++; if (fif.id_pc !== 32'h0)             begin errors++; $display("FAIL wrap_pc_zero: got %h want 0", fif.id_pc); end
        checks++; if (fif.id_inst !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_inst_zero: got %h want %h", fif.id_inst, mem_word(32'h0)); end
        step();
    endtask

    task automatic test_reset_mid();
        fif.id_ready = 1'b0;
        repeat (8) step();
        fif.id_ready = 1'b1;
        step();
        fif.id_ready = 1'b0;
        rv_hold = 1'b1;
        repeat (3) step();
        checks++; if (fif.id_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", fif.id_valid); end
        checks++; if (fif.mem_req !== 1'b0)  begin errors++; $display("FAIL rm_pre_req: got %b want 0", fif.mem_req); end
        rst = 1'b0;
        step();
        checks++; if (fif.id_valid !== 1'b0)  begin errors++; $display("FAIL rm_valid: got %b want 0", fif.id_valid); end
        checks++; if (fif.mem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 0", fif.mem_addr); end
        checks++; if (fif.mem_req !== 1'b0)   begin errors++; $display("FAIL rm_req: got %b want 0", fif.mem_req); end
        checks++; if (fif.misalign !== 1'b0)  begin errors++; $display("FAIL rm_misalign: got %b want 0", fif.misalign); end
`ifdef IFETCH_PERF_EN
        checks++; if (perf_fetch_cnt !== 32'h0) begin errors++; $display("FAIL rm_perf_fetch: got %0d want 0", perf_fetch_cnt); end
        checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL rm_perf_stall: got %0d want 0", perf_stall_cnt); end
`endif
        rv_hold = 1'b0;
        rst = 1'b1;
        fif.id_ready = 1'b1;
        wait_valid("rm_valid_restart");
        checks++; if (fif.id_pc !== 32'h0)             begin errors++; $display("FAIL rm_restart_pc: got %h want 0", fif.id_pc); end
        checks++; if (fif.id_inst !== mem_word(32'h0)) begin errors++; $display("FAIL rm_restart_inst: got %h want %h", fif.id_inst, mem_word(32'h0)); end
    endtask

    initial begin
        fif.redirect    = 1'b0;
        fif.redirect_pc = 32'h0;
        fif.id_ready    = 1'b0;
        test_reset();
        test_fetch_seq();
        test_backpressure();
        test_redirect_wait();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
